// File: rtl/adc_capture_pkg.sv
// Shared state encoding and default parameter values for the ADC capture packer.
package adc_capture_pkg;

  localparam int LANES_DEF  = 6;
  localparam int SAMP_W_DEF = 16;
  localparam int SPW_DEF    = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int ERR_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_ramp_check.sv
// Ramp integrity checker: each enabled sample must equal the previous one plus one.
// Built only when ADC_CAPTURE_RAMP_CHECK_EN is defined; the error count saturates.
module adc_ramp_check
  import adc_capture_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    data_i,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic [DW-1:0]    prev_q;
  logic             seen_q;
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      seen_q <= 1'b0;
      err_q  <= '0;
    end else if (clr_i) begin
      seen_q <= 1'b0;
      err_q  <= '0;
    end else if (en_i) begin
      prev_q <= data_i;
      seen_q <= 1'b1;
      if (seen_q && (data_i != prev_q + DW'(1)) && (err_q != '1))
        err_q <= err_q + ERR_W'(1);
    end
  end

  assign err_cnt_o = err_q;

endmodule

// File: rtl/adc_capture_pack.sv
// DDR ADC capture: forms samples from rising/falling lane bits and packs SPW per word.
// Optional ramp checker enabled by defining ADC_CAPTURE_RAMP_CHECK_EN.
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | armed, waiting for trig
//   CAPTURE | packing samples into words
//   DONE    | cap_len words written, waiting for arm low
module adc_capture_pack
  import adc_capture_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int SPW    = SPW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  dco,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      dr,
  input  logic [LANES-1:0]      df,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      cap_len,
  output logic [SAMP_W*SPW-1:0] wr_data,
  output logic                  wr_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int HALF_W = SAMP_W / 2;
  localparam int WORD_W = SAMP_W * SPW;
  localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;

  cap_state_e        state_q;
  logic [LANES-1:0]  df_d_q;
  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              wr_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [SLOT_W-1:0] slot_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [CNT_W-1:0]  cap_len_q;

  logic [SAMP_W-1:0] samp_d;
  logic [WORD_W-1:0] acc_d;
  logic [CNT_W-1:0]  wcnt_d;

  assign samp_d = {HALF_W'(dr), HALF_W'(df_d_q)};
  // Shifting left keeps the oldest sample of the word in the top slot.
  assign acc_d  = (acc_q << SAMP_W) | WORD_W'(samp_d);
  assign wcnt_d = wcnt_q + CNT_W'(1);

  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      df_d_q     <= '0;
      acc_q      <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      slot_q     <= '0;
      wcnt_q     <= '0;
      cap_len_q  <= '0;
    end else begin
      df_d_q     <= df;
      wr_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (abort || !arm) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (trig) begin
            state_q   <= ST_CAPTURE;
            cap_len_q <= cap_len;
            slot_q    <= '0;
            wcnt_q    <= '0;
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            if (slot_q == SLOT_W'(SPW - 1)) begin
              slot_q     <= '0;
              wr_data_q  <= acc_d;
              wr_valid_q <= 1'b1;
              wcnt_q     <= wcnt_d;
              if ((cap_len_q != '0) && (wcnt_d == cap_len_q)) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (abort || !arm) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef ADC_CAPTURE_RAMP_CHECK_EN
  logic ramp_clr;
  logic ramp_en;

  assign ramp_clr = (state_q == ST_IDLE) && arm;
  assign ramp_en  = (state_q == ST_CAPTURE);

  adc_ramp_check #(
    .DW (2 * LANES)
  ) u_ramp_check (
    .clk       (dco),
    .rst_n     (rst_n),
    .clr_i     (ramp_clr),
    .en_i      (ramp_en),
    .data_i    ({dr, df_d_q}),
    .err_cnt_o (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_capture_pack.sv
// Scoreboard bench for adc_capture_pack: driver pushes expected words, monitor pops on wr_valid.
module tb_adc_capture_pack;
  import adc_capture_pkg::*;

  localparam int L  = 6;
  localparam int SW = 16;
  localparam int SPW = 4;
  localparam int CW = 16;
  localparam int WW = SW * SPW;

  logic          dco = 1'b0;
  logic          rst_n = 1'b1;
  logic [L-1:0]  dr = '0;
  logic [L-1:0]  df = '0;
  logic          arm = 1'b0, trig = 1'b0, abort = 1'b0;
  logic [CW-1:0] cap_len = '0;
  logic [WW-1:0] wr_data;
  logic          wr_valid, busy, done;
  logic [15:0]   err_cnt;

  logic          arm2 = 1'b0, trig2 = 1'b0, abort2 = 1'b0;
  logic [7:0]    dr2 = 8'hA5;
  logic [7:0]    df2 = 8'h3C;
  logic [15:0]   cap_len2 = 16'd1;
  logic [31:0]   wr_data2;
  logic          wr_valid2, busy2, done2;
  logic [15:0]   err_cnt2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_strobe = 0;

  typedef struct {
    logic [WW-1:0] data;
    int            at;
  } exp_t;

  exp_t          expq[$];
  exp_t          mon_e;
  logic [2*L-1:0] samp[$];

  adc_capture_pack dut (
    .dco(dco), .rst_n(rst_n), .dr(dr), .df(df), .arm(arm), .trig(trig), .abort(abort),
    .cap_len(cap_len), .wr_data(wr_data), .wr_valid(wr_valid), .busy(busy), .done(done),
    .err_cnt(err_cnt)
  );

  adc_capture_pack #(.LANES(8), .SAMP_W(16), .SPW(2), .CNT_W(16)) dut2 (
    .dco(dco), .rst_n(rst_n), .dr(dr2), .df(df2), .arm(arm2), .trig(trig2), .abort(abort2),
    .cap_len(cap_len2), .wr_data(wr_data2), .wr_valid(wr_valid2), .busy(busy2), .done(done2),
    .err_cnt(err_cnt2)
  );

  always #5 dco = ~dco;
  always @(posedge dco) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot value is hi * 2^(SW/2) + lo; the oldest sample ends up most significant.
  function automatic logic [WW-1:0] pack_word(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < SPW; j++)
      w = (w << SW) | (WW'(samp[base+j][2*L-1:L]) << (SW/2)) | WW'(samp[base+j][L-1:0]);
    return w;
  endfunction

  initial forever begin
    @(posedge dco);
    #1;
    if (wr_valid) begin
      n_strobe++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got data %0h at cycle %0d, expected no strobe", wr_data, cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("word_data", wr_data, mon_e.data);
        chk("word_cycle", cyc, mon_e.at);
      end
    end
  end

  // Drives one arm/trig/capture sequence; the capture starts the cycle after the
  // first ARMED cycle that sees trig. abort_at < 0 means no abort.
  task automatic run_cap(input int clen, input int ns, input int trig_k, input int abort_at);
    int cs, nw, base, total, i_r, i_f;
    cs = ((trig_k < 1) ? 1 : trig_k) + 1;
    nw = (abort_at >= 0) ? abort_at / SPW : ns / SPW;
    if (clen != 0 && nw > clen) nw = clen;
    @(negedge dco);
    base = cyc;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.data = pack_word(w * SPW);
      e.at   = base + cs + SPW * w + SPW;
      expq.push_back(e);
    end
    cap_len = CW'(clen);
    total = cs + ((abort_at >= 0) ? abort_at + 1 : ns);
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge dco);
      arm   = 1'b1;
      trig  = (c >= trig_k);
      abort = (abort_at >= 0) && (c == cs + abort_at);
      i_r = c - cs;
      i_f = c + 1 - cs;
      dr = (i_r >= 0 && i_r < samp.size()) ? samp[i_r][2*L-1:L] : L'($urandom);
      df = (i_f >= 0 && i_f < samp.size()) ? samp[i_f][L-1:0] : L'($urandom);
      if (c == cs) begin
        chk("busy_in_capture", busy, 1);
        chk("done_in_capture", done, 0);
      end
    end
  endtask

  task automatic finish_done(input bit check_err, input int exp_err);
    @(negedge dco);
    trig = 1'b0;
    chk("done_set", done, 1);
    chk("busy_clear_done", busy, 0);
    if (check_err) chk("err_cnt", err_cnt, exp_err);
    @(negedge dco);
    chk("done_hold_arm_high", done, 1);
    arm = 1'b0;
    @(negedge dco);
    chk("done_clear_arm_low", done, 0);
  endtask

  task automatic finish_abort();
    @(negedge dco);
    abort = 1'b0;
    arm   = 1'b0;
    trig  = 1'b0;
    chk("busy_after_abort", busy, 0);
    chk("done_after_abort", done, 0);
    chk("valid_after_abort", wr_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int clen, k, nstrobe0, n2;
    logic [2*L-1:0] v;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wr_data2", wr_data2, 0);
    repeat (2) @(negedge dco);
    rst_n = 1'b1;

    // trig alone in IDLE does nothing
    @(negedge dco);
    trig = 1'b1;
    repeat (3) @(negedge dco);
    chk("idle_trig_only_busy", busy, 0);
    trig = 1'b0;

    // Second configuration: LANES=8, SPW=2, constant lanes
    arm2 = 1'b1;
    trig2 = 1'b1;
    n2 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge dco);
      if (wr_valid2) begin
        n2++;
        chk("lanes8_word", wr_data2, 32'hA53CA53C);
      end
    end
    chk("lanes8_strobes", n2, 1);
    chk("lanes8_done", done2, 1);
    arm2 = 1'b0;
    trig2 = 1'b0;

    // Ramp, cap_len=2, arm then trig
    samp.delete();
    v = 12'($urandom);
    for (int i = 0; i < 8; i++) samp.push_back(v + 12'(i));
    run_cap(2, 8, 1, -1);
    finish_done(1'b1, 0);

    // Random words, random cap_len and trig timing
    for (int it = 0; it < 4; it++) begin
      clen = $urandom_range(1, 3);
      k = $urandom_range(0, 3);
      samp.delete();
      for (int i = 0; i < clen * SPW; i++) samp.push_back(12'($urandom));
      run_cap(clen, clen * SPW, k, -1);
      finish_done(1'b0, 0);
    end

    // Ramp with three skipped values
    samp.delete();
    v = 12'($urandom);
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 9 || i == 13) v = v + 12'd1;
      samp.push_back(v);
      v = v + 12'd1;
    end
    run_cap(4, 16, 0, -1);
`ifdef ADC_CAPTURE_RAMP_CHECK_EN
    finish_done(1'b1, 3);
`else
    finish_done(1'b1, 0);
`endif

    // Abort on the cycle that would complete the only word
    samp.delete();
    for (int i = 0; i < 4; i++) samp.push_back(12'($urandom));
    run_cap(1, 4, 2, 3);
    finish_abort();

    // Continuous capture, abort after 25 words plus a partial word
    samp.delete();
    for (int i = 0; i < 103; i++) samp.push_back(12'($urandom));
    nstrobe0 = n_strobe;
    run_cap(0, 103, 1, 102);
    finish_abort();
    chk("continuous_strobes", n_strobe - nstrobe0, 25);

    // Reset mid-word during capture
    samp.delete();
    for (int i = 0; i < 6; i++) samp.push_back(12'(i + 1));
    run_cap(0, 6, 1, -1);
    @(negedge dco);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_wr_valid", wr_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    arm = 1'b0;
    trig = 1'b0;
    repeat (2) @(negedge dco);
    rst_n = 1'b1;
    repeat (3) @(negedge dco);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    repeat (4) @(negedge dco);
    chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
